// File: rtl/prog_ctr_pkg.sv
// Shared types for the program-counter sequencer: FSM states, next-PC
// selector and a width helper for the program-select port.
package prog_ctr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pcs_state_t;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    INC  = 3'd1,
    ABS  = 3'd2,
    REL  = 3'd3,
    RET  = 3'd4
  } npc_sel_t;

  // A one-program build still needs a 1-bit select port.
  function automatic int sel_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address stack with a circular write pointer: a push into a full
// stack overwrites the oldest entry; depth saturates and err is sticky.
module ret_addr_stack #(
  parameter int PC_W      = 10,
  parameter int RAS_DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr,
  input  logic [PC_W-1:0]            din,
  output logic [PC_W-1:0]            top,
  output logic [$clog2(RAS_DEPTH):0] depth,
  output logic                       err
);

  localparam int PTR_W   = $clog2(RAS_DEPTH);
  localparam int DEPTH_W = PTR_W + 1;
  localparam logic [DEPTH_W-1:0] FULL      = DEPTH_W'(RAS_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]   PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0]    r_mem [RAS_DEPTH];
  logic [PTR_W-1:0]   r_wp;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_err;
  logic [PTR_W-1:0]   w_rd_ptr;

  assign w_rd_ptr = r_wp - PTR_ONE;
  assign top      = r_mem[w_rd_ptr];
  assign depth    = r_depth;
  assign err      = r_err;

  // Clear wins over pop, pop over push; an empty pop only flags the error.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_mem[i] <= {PC_W{1'b0}};
      end
      r_wp    <= {PTR_W{1'b0}};
      r_depth <= {DEPTH_W{1'b0}};
      r_err   <= 1'b0;
    end else if (clr) begin
      r_wp    <= {PTR_W{1'b0}};
      r_depth <= {DEPTH_W{1'b0}};
      r_err   <= 1'b0;
    end else if (pop) begin
      if (r_depth != {DEPTH_W{1'b0}}) begin
        r_wp    <= w_rd_ptr;
        r_depth <= r_depth - DEPTH_ONE;
      end else begin
        r_err <= 1'b1;
      end
    end else if (push) begin
      r_mem[r_wp] <= din;
      r_wp        <= r_wp + PTR_ONE;
      if (r_depth == FULL) begin
        r_err <= 1'b1;
      end else begin
        r_depth <= r_depth + DEPTH_ONE;
      end
    end
  end

endmodule

// File: rtl/prog_ctr_seq.sv
// Program-counter sequencer: IDLE/RUN/HALTED control, per-program start
// vectors, absolute/relative branches and call/return via ret_addr_stack.
module prog_ctr_seq
  import prog_ctr_pkg::*;
#(
  parameter int                        PC_W       = 10,
  parameter int                        NUM_PROGS  = 3,
  parameter logic [NUM_PROGS*PC_W-1:0] START_VECS = {10'd512, 10'd256, 10'd0},
  parameter int                        RAS_DEPTH  = 4
) (
  input  logic                              Clk,
  input  logic                              Reset_n,
  input  logic                              Start,
  input  logic [sel_width(NUM_PROGS)-1:0]   ProgSel,
  input  logic                              Stall,
  input  logic                              HaltReq,
  input  logic                              BranchAbs,
  input  logic                              BranchRelEn,
  input  logic                              ALU_flag,
  input  logic                              Call,
  input  logic                              Ret,
  input  logic [PC_W-1:0]                   Target,
  output logic [PC_W-1:0]                   ProgCtr,
  output logic                              Running,
  output logic                              Done,
  output logic [$clog2(RAS_DEPTH):0]        RasDepth,
  output logic                              RasErr
);

  localparam int DEPTH_W = $clog2(RAS_DEPTH) + 1;
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  pcs_state_t         r_state;
  pcs_state_t         w_state_nxt;
  npc_sel_t           w_sel;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [PC_W-1:0]    w_start_vec;
  logic [PC_W-1:0]    w_ras_top;
  logic [DEPTH_W-1:0] w_ras_depth;
  logic               w_ras_err;
  logic               w_push;
  logic               w_pop;
  logic               w_clr;
  logic               r_running;
  logic               r_done;
  int                 w_prog_idx;

  // Out-of-range program selects fall back to entry 0.
  always_comb begin
    w_prog_idx = 0;
    if (32'(ProgSel) < NUM_PROGS) begin
      w_prog_idx = int'(ProgSel);
    end else begin
      w_prog_idx = 0;
    end
    w_start_vec = START_VECS[w_prog_idx*PC_W +: PC_W];
  end

  // Next-state and next-PC source; Start overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    w_sel       = HOLD;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clr       = 1'b0;
    if (Start) begin
      w_state_nxt = IDLE;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = RUN;
        end
        RUN: begin
          if (Stall) begin
            w_sel = HOLD;
          end else if (HaltReq) begin
            w_state_nxt = HALTED;
            w_sel       = HOLD;
          end else if (Ret) begin
            w_pop = 1'b1;
            w_sel = (w_ras_depth != {DEPTH_W{1'b0}}) ? RET : INC;
          end else if (Call) begin
            w_push = 1'b1;
            w_sel  = ABS;
          end else if (BranchAbs) begin
            w_sel = ABS;
          end else if (BranchRelEn && ALU_flag) begin
            w_sel = REL;
          end else begin
            w_sel = INC;
          end
        end
        HALTED: begin
          w_state_nxt = HALTED;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // PC arithmetic wraps naturally at PC_W bits; a relative Target is signed.
  always_comb begin
    w_pc_nxt = r_pc;
    if (Start) begin
      w_pc_nxt = w_start_vec;
    end else begin
      case (w_sel)
        HOLD:    w_pc_nxt = r_pc;
        INC:     w_pc_nxt = r_pc + PC_ONE;
        ABS:     w_pc_nxt = Target;
        REL:     w_pc_nxt = r_pc + Target;
        RET:     w_pc_nxt = w_ras_top;
        default: w_pc_nxt = r_pc;
      endcase
    end
  end

  // Status flags are registered alongside the state so they never glitch.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= IDLE;
      r_pc      <= {PC_W{1'b0}};
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_running <= (w_state_nxt == RUN);
      r_done    <= (w_state_nxt == HALTED);
    end
  end

  ret_addr_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .clr     (w_clr),
    .din     (r_pc + PC_ONE),
    .top     (w_ras_top),
    .depth   (w_ras_depth),
    .err     (w_ras_err)
  );

  assign ProgCtr  = r_pc;
  assign Running  = r_running;
  assign Done     = r_done;
  assign RasDepth = w_ras_depth;
  assign RasErr   = w_ras_err;

endmodule

// File: tb/tb_prog_ctr_seq.sv
// Directed table-driven bench for prog_ctr_seq plus hand-written sequences
// for reset state and asynchronous mid-run reset.
module tb_prog_ctr_seq;

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_STALL = 7'b1000000;
  localparam logic [6:0] C_HALT  = 7'b0100000;
  localparam logic [6:0] C_ABS   = 7'b0010000;
  localparam logic [6:0] C_REL   = 7'b0001000;
  localparam logic [6:0] C_FLAG  = 7'b0000100;
  localparam logic [6:0] C_CALL  = 7'b0000010;
  localparam logic [6:0] C_RET   = 7'b0000001;

  typedef struct {
    logic       st;
    logic [1:0] sel;
    logic [6:0] ctl;
    logic [9:0] tgt;
    logic [9:0] pc;
    logic       run;
    logic       done;
    logic [2:0] dep;
    logic       err;
  } vec_t;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Start = 1'b0;
  logic [1:0] ProgSel = 2'd0;
  logic       Stall = 1'b0, HaltReq = 1'b0, BranchAbs = 1'b0, BranchRelEn = 1'b0;
  logic       ALU_flag = 1'b0, Call = 1'b0, Ret = 1'b0;
  logic [9:0] Target = 10'd0;
  logic [9:0] ProgCtr;
  logic       Running, Done, RasErr;
  logic [2:0] RasDepth;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  always #5 Clk = ~Clk;

  prog_ctr_seq #(
    .PC_W       (10),
    .NUM_PROGS  (3),
    .START_VECS ({10'd512, 10'd256, 10'd0}),
    .RAS_DEPTH  (4)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .ProgSel     (ProgSel),
    .Stall       (Stall),
    .HaltReq     (HaltReq),
    .BranchAbs   (BranchAbs),
    .BranchRelEn (BranchRelEn),
    .ALU_flag    (ALU_flag),
    .Call        (Call),
    .Ret         (Ret),
    .Target      (Target),
    .ProgCtr     (ProgCtr),
    .Running     (Running),
    .Done        (Done),
    .RasDepth    (RasDepth),
    .RasErr      (RasErr)
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic [1:0] sel, input logic [6:0] ctl,
                     input logic [9:0] tgt, input logic [9:0] pc, input logic run,
                     input logic done, input logic [2:0] dep, input logic err);
    vec_t v;
    v.st = st; v.sel = sel; v.ctl = ctl; v.tgt = tgt; v.pc = pc;
    v.run = run; v.done = done; v.dep = dep; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input logic [1:0] sel, input logic [6:0] ctl, input logic [9:0] tgt);
    Start = st;
    ProgSel = sel;
    {Stall, HaltReq, BranchAbs, BranchRelEn, ALU_flag, Call, Ret} = ctl;
    Target = tgt;
  endtask

  task automatic chk_all(input int idx, input logic [9:0] pc, input logic run,
                         input logic done, input logic [2:0] dep, input logic err);
    chk("pc", idx, 32'(ProgCtr), 32'(pc));
    chk("running", idx, 32'(Running), 32'(run));
    chk("done", idx, 32'(Done), 32'(done));
    chk("depth", idx, 32'(RasDepth), 32'(dep));
    chk("raserr", idx, 32'(RasErr), 32'(err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Start vector, then the one-cycle IDLE->RUN latency.
    add(1'b1, 2'd1, C_NONE, 10'd0, 10'd256, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b1, 2'd1, C_NONE, 10'd0, 10'd256, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd1, C_NONE, 10'd0, 10'd256, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_NONE, 10'd0, 10'd257, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_NONE, 10'd0, 10'd258, 1'b1, 1'b0, 3'd0, 1'b0);
    // Relative branches and wrap at the top of the address space.
    add(1'b0, 2'd0, C_ABS, 10'd10, 10'd10, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_REL | C_FLAG, 10'h3FE, 10'd8, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_ABS, 10'd10, 10'd10, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_REL, 10'h3FE, 10'd11, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_FLAG, 10'h3FE, 10'd12, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_ABS, 10'd1023, 10'd1023, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_NONE, 10'd0, 10'd0, 1'b1, 1'b0, 3'd0, 1'b0);
    // Simple call/return, Call+Ret together, stall masking a call.
    add(1'b0, 2'd0, C_ABS, 10'd20, 10'd20, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_CALL, 10'd100, 10'd100, 1'b1, 1'b0, 3'd1, 1'b0);
    add(1'b0, 2'd0, C_RET, 10'd0, 10'd21, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_CALL, 10'd200, 10'd200, 1'b1, 1'b0, 3'd1, 1'b0);
    add(1'b0, 2'd0, C_CALL | C_RET, 10'd300, 10'd22, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_STALL | C_CALL, 10'd500, 10'd22, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_REL | C_FLAG, 10'd5, 10'd27, 1'b1, 1'b0, 3'd0, 1'b0);
    // Five nested calls overflow a 4-deep stack, then unwind and underflow.
    add(1'b0, 2'd0, C_ABS, 10'd1, 10'd1, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_CALL, 10'd101, 10'd101, 1'b1, 1'b0, 3'd1, 1'b0);
    add(1'b0, 2'd0, C_CALL, 10'd201, 10'd201, 1'b1, 1'b0, 3'd2, 1'b0);
    add(1'b0, 2'd0, C_CALL, 10'd301, 10'd301, 1'b1, 1'b0, 3'd3, 1'b0);
    add(1'b0, 2'd0, C_CALL, 10'd401, 10'd401, 1'b1, 1'b0, 3'd4, 1'b0);
    add(1'b0, 2'd0, C_CALL, 10'd501, 10'd501, 1'b1, 1'b0, 3'd4, 1'b1);
    add(1'b0, 2'd0, C_RET, 10'd0, 10'd402, 1'b1, 1'b0, 3'd3, 1'b1);
    add(1'b0, 2'd0, C_RET, 10'd0, 10'd302, 1'b1, 1'b0, 3'd2, 1'b1);
    add(1'b0, 2'd0, C_RET, 10'd0, 10'd202, 1'b1, 1'b0, 3'd1, 1'b1);
    add(1'b0, 2'd0, C_RET, 10'd0, 10'd102, 1'b1, 1'b0, 3'd0, 1'b1);
    add(1'b0, 2'd0, C_RET, 10'd0, 10'd103, 1'b1, 1'b0, 3'd0, 1'b1);
    // Halt, then ten cycles of toggling BranchAbs that must be ignored.
    add(1'b0, 2'd0, C_ABS, 10'd50, 10'd50, 1'b1, 1'b0, 3'd0, 1'b1);
    add(1'b0, 2'd0, C_HALT, 10'd0, 10'd50, 1'b0, 1'b1, 3'd0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      add(1'b0, 2'd0, (k % 2 == 0) ? C_ABS : C_NONE, 10'd7, 10'd50, 1'b0, 1'b1, 3'd0, 1'b1);
    end
    // Start exits HALTED and clears RasErr; out-of-range ProgSel uses entry 0.
    add(1'b1, 2'd2, C_NONE, 10'd0, 10'd512, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_NONE, 10'd0, 10'd512, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_NONE, 10'd0, 10'd513, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b1, 2'd3, C_NONE, 10'd0, 10'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_NONE, 10'd0, 10'd0, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_NONE, 10'd0, 10'd1, 1'b1, 1'b0, 3'd0, 1'b0);
    // Negative offset wraps below zero; Stall outranks HaltReq.
    add(1'b0, 2'd0, C_REL | C_FLAG, 10'h3FE, 10'd1023, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_STALL | C_HALT, 10'd0, 10'd1023, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b0, 2'd0, C_HALT, 10'd0, 10'd1023, 1'b0, 1'b1, 3'd0, 1'b0);

    // Reset state while reset is still asserted.
    #2;
    chk_all(-1, 10'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].sel, vecs[i].ctl, vecs[i].tgt);
      @(posedge Clk);
      #1;
      chk_all(i, vecs[i].pc, vecs[i].run, vecs[i].done, vecs[i].dep, vecs[i].err);
    end

    // Reach RUN at PC=300 with two stacked returns.
    drive(1'b1, 2'd0, C_NONE, 10'd0);
    @(posedge Clk); #1;
    drive(1'b0, 2'd0, C_NONE, 10'd0);
    @(posedge Clk); #1;
    drive(1'b0, 2'd0, C_CALL, 10'd100);
    @(posedge Clk); #1;
    drive(1'b0, 2'd0, C_CALL, 10'd300);
    @(posedge Clk); #1;
    chk_all(100, 10'd300, 1'b1, 1'b0, 3'd2, 1'b0);

    // Asynchronous reset mid-cycle with a push still requested.
    drive(1'b0, 2'd0, C_CALL, 10'd400);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_all(101, 10'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    drive(1'b0, 2'd0, C_NONE, 10'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    chk_all(102, 10'd0, 1'b1, 1'b0, 3'd0, 1'b0);
    @(posedge Clk); #1;
    chk_all(103, 10'd1, 1'b1, 1'b0, 3'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_ctr_seq.md
# prog_ctr_seq

Parametrised program-counter sequencer for the CSE141L processor. It supersedes the single-program fetch counter with the following additions:
- per-program start vectors selected at Start;
- absolute and signed-relative branches;
- a call/return address stack;
- stall and halt handling;
- an explicit IDLE/RUN/HALTED state machine.

It sits between the decoder/ALU and the instruction ROM, and drives the ROM address every cycle.

## Interface
Parameters:
- PC_W, 10, program-counter width; ROM holds 2^PC_W words
- NUM_PROGS, 3, number of selectable programs
- START_VECS, {10'd512,10'd256,10'd0}, packed NUM_PROGS×PC_W start addresses; entry i sits at bits [i*PC_W +: PC_W]
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2)

Ports:
- Clk  in  1  clock; all state changes on posedge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  load start vector and hold while high
- ProgSel  in  $clog2(NUM_PROGS)  program chosen at Start
- Stall  in  1  freeze PC and stack this cycle
- HaltReq  in  1  current instruction is halt
- BranchAbs  in  1  unconditional jump to Target
- BranchRelEn  in  1  conditional relative jump
- ALU_flag  in  1  condition for BranchRelEn
- Call  in  1  push return address, jump to Target
- Ret  in  1  pop return address into PC
- Target  in  PC_W  absolute address (BranchAbs/Call) or signed two's-complement offset (BranchRelEn)
- ProgCtr  out  PC_W  instruction address
- Running  out  1  state == RUN
- Done  out  1  state == HALTED
- RasDepth  out  $clog2(RAS_DEPTH)+1  valid stack entries
- RasErr  out  1  sticky stack overflow/underflow flag

## Operation
States: IDLE, RUN, HALTED.

Reset values:
- state = IDLE
- ProgCtr = 0
- RasDepth = 0
- RasErr = 0
- stack contents = 0

Start = 1, in any state and overriding everything except reset:
- ProgCtr ← START_VECS[ProgSel]; a ProgSel ≥ NUM_PROGS selects entry 0
- state ← IDLE
- RasDepth ← 0
- RasErr ← 0

IDLE with Start = 0:
- state ← RUN
- ProgCtr holds; control inputs are ignored.

RUN, evaluated in priority order (first true wins):
1. Stall → hold everything.
2. HaltReq → state ← HALTED, ProgCtr holds.
3. Ret:
   - if RasDepth > 0: pop top into ProgCtr, RasDepth − 1;
   - if RasDepth = 0: ProgCtr ← ProgCtr+1, RasErr ← 1.
4. Call → push ProgCtr+1, ProgCtr ← Target.
   - When full: the oldest entry is overwritten (circular), RasDepth stays at RAS_DEPTH, RasErr ← 1.
5. BranchAbs → ProgCtr ← Target.
6. BranchRelEn && ALU_flag → ProgCtr ← ProgCtr + Target.
7. Otherwise → ProgCtr ← ProgCtr+1.

HALTED:
- Everything holds; all controls are ignored.
- Exit is only via Start.

Arithmetic and simultaneous-event rules:
- All PC arithmetic is modulo 2^PC_W: the maximum address + 1 wraps to 0, and a negative offset wraps downward.
- Call and Ret asserted together: Ret wins, Call is dropped and no push occurs.
- The condition for rule 6 is BranchRelEn && ALU_flag; the state of ALU_flag alone has no effect.

## Timing
- Every transition is one cycle: control inputs are sampled at posedge N, and the new ProgCtr is visible after posedge N.
- Latency from Start falling to the first increment:
  - cycle after the fall: IDLE→RUN, ProgCtr still at the start vector;
  - following posedge: the next-PC computation takes effect.
- Asynchronous reset clears all state immediately and mid-operation, including an in-flight push or pop. Deassertion is synchronised externally.
- Running and Done are decoded from registered state, so they are glitch-free and change in the same cycle as the state.
- RasErr stays set until Start or reset.

## Structure
- Package prog_ctr_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, HALTED} pcs_state_t;
  - next-PC select enum (HOLD, INC, ABS, REL, RET).
- Sub-module ret_addr_stack:
  - parameters PC_W and RAS_DEPTH;
  - inputs push, pop, clr, din; outputs top, depth, err;
  - circular write pointer, saturating depth counter.
- Top: state register, priority mux, PC register.

## Test plan
- Reset, ProgSel=1, Start pulse for 2 cycles then low → ProgCtr = 256, 256, 256 (IDLE→RUN), then 257, 258.
- From PC=10: BranchRelEn=1, ALU_flag=1, Target=10'h3FE (−2) → 8. Same with ALU_flag=0 → 11. PC=1023 with no branch → 0.
- PC=20: Call with Target=100 → PC=100, RasDepth=1. Ret → PC=21, RasDepth=0.
- 5 nested Calls from PCs 1, 101, 201, 301, 401 with Target=PC+100 (RAS_DEPTH=4) → RasErr=1, RasDepth=4. 4 Rets return 402, 302, 202, 102. A 5th Ret → RasDepth=0 gives PC+1, RasErr stays 1.
- Stall asserted together with Call → PC, RasDepth unchanged. HaltReq at PC=50 → Done=1, PC=50 held for 10 cycles despite BranchAbs toggling. Start with ProgSel=2 → PC=512, Done=0.
- Reset_n pulsed low mid-cycle during RUN at PC=300 with RasDepth=2 → ProgCtr=0, RasDepth=0, state IDLE, immediately without waiting for a clock edge.
